// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one gate-delay ALU among N_REQ requesters.
// Optional macro ALU_ARB_PRIO0_EN gives requester 0 fixed top priority.
module alu_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int SETTLE_CYCLES = 2,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [2:0]             alu_sel,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [2:0]             alu_flags,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IW-1:0]          resp_id,
  output logic [WIDTH-1:0]       resp_result,
  output logic [2:0]             resp_flags
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, id_q, gnt_idx, resp_id_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] sel_q, resp_flags_q;
  logic [WIDTH-1:0] a_q, b_q, resp_result_q;
  logic gnt_any;
  // Descending scan so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef ALU_ARB_PRIO0_EN
      if (req_valid[(int'(rr_ptr_q) + k) % N_REQ] && ((int'(rr_ptr_q) + k) % N_REQ) != 0) begin
`else
      if (req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
`endif
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
`ifdef ALU_ARB_PRIO0_EN
    if (req_valid[0]) begin
      gnt_any = 1'b1;
      gnt_idx = '0;
    end
`endif
  end
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_any && rst_n) req_ready[gnt_idx] = 1'b1;
  end
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        state_d  = SETTLE;
        cnt_d    = CW'(SETTLE_CYCLES - 1);
        rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef ALU_ARB_PRIO0_EN
        if (gnt_idx == '0) rr_ptr_d = rr_ptr_q;
`endif
      end
      SETTLE: if (cnt_q == '0) state_d = RESP; else cnt_d = cnt_q - 1'b1;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      id_q          <= '0;
      sel_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (state_q == IDLE && gnt_any) begin
        id_q  <= gnt_idx;
        sel_q <= req_op[3*gnt_idx +: 3];
        a_q   <= req_a[WIDTH*gnt_idx +: WIDTH];
        b_q   <= req_b[WIDTH*gnt_idx +: WIDTH];
      end
      if (state_q == SETTLE && cnt_q == '0) begin
        resp_id_q     <= id_q;
        resp_result_q <= alu_result;
        resp_flags_q  <= alu_flags;
      end
    end
  end
  assign alu_sel     = sel_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp_valid  = (state_q == RESP);
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench with a behavioural ALU and round-robin reference model.
module tb_alu_share_arbiter;
  localparam int N = 4, W = 32, S = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [2:0] alu_sel, alu_flags, resp_flags;
  logic [W-1:0] alu_a, alu_b, alu_result, resp_result;
  logic resp_valid, resp_ready;
  logic [1:0] resp_id;
  logic [W+2:0] perturb;
  typedef struct packed {logic [1:0] id; logic [2:0] fl; logic [W-1:0] res;} exp_t;
  exp_t sb[$];
  exp_t cur, e;
  int errors = 0, checks = 0;
  int ptr = 0, busy = 0, lat = 0, seen = 0, n_grants = 0, cyc = 0, g;
  int glog[$], gcyc[$];
  logic [W+2:0] r;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_sel(alu_sel), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .alu_flags(alu_flags), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result), .resp_flags(resp_flags)
  );

  // Returns {overflow, carry, zero, result}.
  function automatic logic [W+2:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    logic [W-1:0] res;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: begin s = {1'b0, a} + {1'b0, b}; res = s[W-1:0]; c = s[W]; v = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]); end
      3'd3: begin s = {1'b0, a} - {1'b0, b}; res = s[W-1:0]; c = s[W]; v = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]); end
      3'd4: res = a ^ b;
      3'd5: res = {{(W-1){1'b0}}, a < b};
      3'd6: res = ~(a | b);
      default: res = b;
    endcase
    return {v, c, res == '0, res};
  endfunction

  assign {alu_flags, alu_result} = alu_f(alu_sel, alu_a, alu_b) ^ perturb;

  function automatic int winner(input logic [N-1:0] v, input int p);
`ifdef ALU_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int o = 0; o < N; o++) begin
      int i;
      i = (p + o) % N;
`ifdef ALU_ARB_PRIO0_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete(); ptr = 0; busy = 0; seen = 0; lat = 0;
    end else if (busy != 0) begin
      lat++;
      chk("busy_no_grant", 64'(req_ready), 0);
      if (resp_valid) begin
        if (seen == 0) begin
          chk("latency", 64'(lat), S + 1);
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            cur = sb.pop_front();
            chk("resp_id", 64'(resp_id), 64'(cur.id));
            chk("resp_result", 64'(resp_result), 64'(cur.res));
            chk("resp_flags", 64'(resp_flags), 64'(cur.fl));
          end
          seen = 1;
        end else begin
          chk("hold_id", 64'(resp_id), 64'(cur.id));
          chk("hold_result", 64'(resp_result), 64'(cur.res));
          chk("hold_flags", 64'(resp_flags), 64'(cur.fl));
        end
        if (resp_ready) begin busy = 0; seen = 0; end
      end
    end else if (req_valid != '0) begin
      g = winner(req_valid, ptr);
      chk("grant", 64'(req_ready), 64'(1) << g);
      r = alu_f(req_op[3*g +: 3], req_a[W*g +: W], req_b[W*g +: W]);
      e.id = 2'(g); e.fl = r[W+2:W]; e.res = r[W-1:0];
      sb.push_back(e);
      busy = 1; lat = 0; n_grants++;
      glog.push_back(g); gcyc.push_back(cyc);
`ifdef ALU_ARB_PRIO0_EN
      if (g != 0) ptr = (g + 1) % N;
`else
      ptr = (g + 1) % N;
`endif
    end else chk("idle_no_grant", 64'(req_ready), 0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grants(input int n);
    int base, t;
    base = n_grants; t = 0;
    while (n_grants < base + n && t < 200) begin tick(); t++; end
    chk("grant_wait", 64'(n_grants >= base + n), 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((busy != 0 || sb.size() != 0) && t < 200) begin tick(); t++; end
    chk("drain", 64'(busy == 0 && sb.size() == 0), 1);
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    while (!resp_valid && t < 50) begin tick(); t++; end
    chk("resp_wait", 64'(resp_valid), 1);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[3*i +: 3] = op; req_a[W*i +: W] = a; req_b[W*i +: W] = b;
  endtask

  task automatic do_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    set_req(i, op, a, b);
    req_valid[i] = 1'b1;
    wait_grants(1);
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk("alu_sel", 64'(alu_sel), 64'(op));
    chk("alu_a", 64'(alu_a), 64'(a));
    chk("alu_b", 64'(alu_b), 64'(b));
  endtask

  initial begin
    int base, n0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1; perturb = '0;
    for (int i = 0; i < N; i++) set_req(i, 3'(i + 2), W'(100 * i + 7), W'(3 * i + 1));
    req_valid = 4'b1111;
    #12;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_alu_sel", 64'(alu_sel), 0);
    chk("rst_alu_a", 64'(alu_a), 0);
    chk("rst_alu_b", 64'(alu_b), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_id", 64'(resp_id), 0);
    chk("rst_resp_result", 64'(resp_result), 0);
    chk("rst_resp_flags", 64'(resp_flags), 0);
    @(posedge clk); #1 rst_n = 1'b1;
`ifdef ALU_ARB_PRIO0_EN
    req_valid = 4'b1001;
    base = glog.size();
    wait_grants(3);
    for (int k = 0; k < 3; k++) chk("prio0_grant", 64'(glog[base + k]), 0);
    req_valid[0] = 1'b0;
    wait_grants(1);
    chk("prio0_drop", 64'(glog[glog.size() - 1]), 3);
    req_valid = '0;
`else
    base = glog.size();
    wait_grants(5);
    req_valid = '0;
    for (int k = 0; k < 5; k++) chk("rr_order", 64'(glog[base + k]), 64'(k % N));
    for (int k = 1; k < 5; k++) chk("rr_spacing", 64'(gcyc[base + k] - gcyc[base + k - 1]), S + 2);
`endif
    drain();
    do_req(2, 3'b010, 32'd5, 32'd3);
    drain();
    resp_ready = 1'b0;
    do_req(1, 3'd3, 32'd10, 32'd20);
    set_req(3, 3'd4, 32'hA5A5_0000, 32'h0000_5A5A);
    req_valid[3] = 1'b1;
    wait_resp();
    n0 = n_grants;
    repeat (5) tick();
    chk("bp_no_grant", 64'(n_grants), 64'(n0));
    chk("bp_resp_valid", 64'(resp_valid), 1);
    resp_ready = 1'b1;
    wait_grants(1);
    req_valid[3] = 1'b0;
    chk("bp_next_grant", 64'(glog[glog.size() - 1]), 3);
    drain();
    resp_ready = 1'b0;
    do_req(0, 3'd0, 32'd0, 32'hFFFF_FFFF);
    wait_resp();
    perturb = {3'b110, 32'hDEAD_BEEF};
    repeat (3) tick();
    chk("flag_capture", 64'(resp_flags), 3'b001);
    chk("flag_result", 64'(resp_result), 0);
    perturb = '0;
    resp_ready = 1'b1;
    drain();
    set_req(1, 3'd2, 32'd40, 32'd2);
    set_req(3, 3'd6, 32'd1, 32'd2);
    req_valid = 4'b1010;
    wait_grants(1);
    chk("pre_rst_grant", 64'(glog[glog.size() - 1]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 0);
    chk("mid_rst_alu_sel", 64'(alu_sel), 0);
    chk("mid_rst_alu_a", 64'(alu_a), 0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_grants(1);
    req_valid[1] = 1'b0;
    chk("regrant_after_rst", 64'(glog[glog.size() - 1]), 1);
    wait_grants(1);
    req_valid = '0;
    chk("grant_after_regrant", 64'(glog[glog.size() - 1]), 3);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates one shared gate-level ALU between N_REQ requesters. It grants one request at a time, round-robin, and registers the winner's opcode and operands onto the ALU inputs. It then waits a fixed settle window for the gate-delay ALU (whose 8:1 result mux is steered by `alu_sel`) to resolve, captures the result and flags, and returns them tagged with the requester id. It sits between the core's issue logic and the ALU datapath.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand/result width.
- `SETTLE_CYCLES`, 2: cycles the ALU inputs are held stable before capture, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester request.
- `req_ready` out N_REQ: one-hot grant; handshake when valid&ready.
- `req_op` in 3*N_REQ: packed opcodes, requester i at [3i+2:3i].
- `req_a` in WIDTH*N_REQ: packed operand A.
- `req_b` in WIDTH*N_REQ: packed operand B.
- `alu_sel` out 3: ALU operation select.
- `alu_a` out WIDTH: ALU operand A.
- `alu_b` out WIDTH: ALU operand B.
- `alu_result` in WIDTH: ALU result.
- `alu_flags` in 3: {overflow, carryout, zero}.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts response.
- `resp_id` out $clog2(N_REQ): granted requester index.
- `resp_result` out WIDTH: captured result.
- `resp_flags` out 3: captured flags.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: if any `req_valid`, assert `req_ready` combinationally for the winner only. On that edge, latch op/a/b/id into the ALU input registers, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE: `alu_sel`/`alu_a`/`alu_b` are held from the registers. The counter decrements each cycle. At counter==0, capture `alu_result`/`alu_flags` into the resp registers and go to RESP.
- RESP: `resp_valid`=1 with stable `resp_*`. When `resp_ready`=1, go to IDLE. The ALU input registers keep their values until the next grant.
- `req_ready` is all-zero in SETTLE and RESP. Requests stay pending, and requesters must hold valid and payload until granted.
- Round-robin: `rr_ptr` marks the highest-priority index. The search runs upward from `rr_ptr` with wrap. After a grant to i, `rr_ptr` ← (i+1) mod N_REQ. With no grant, the pointer is unchanged.
- Opcode is passed through unmodified. The arbiter does no arithmetic on data.

## Timing
- Reset (async, `rst_n`=0): state=IDLE; `rr_ptr`=0. `req_ready`, `alu_sel`, `alu_a`, `alu_b`, `resp_valid`, `resp_id`, `resp_result`, `resp_flags` are all 0.
- Latency: grant edge → `resp_valid` high after SETTLE_CYCLES+1 edges.
- Minimum op spacing is SETTLE_CYCLES+2 cycles (grant, settle, resp with immediate accept, next grant from IDLE).
- `resp_ready` high on the first RESP cycle → response is consumed that edge and `resp_valid` drops the next cycle.
- Reset asserted mid-SETTLE or mid-RESP drops the in-flight operation with no response. Requesters re-issue.
- `req_valid` deasserted before grant: no effect (not a legal protocol use, but tolerated).

## Configuration
- `ALU_ARB_PRIO0_EN` defined: requester 0 always wins when valid. The remaining requesters are arbitrated round-robin among themselves, and a grant to 0 does not move `rr_ptr`.
- Not defined: pure round-robin across all N_REQ requesters, as above.

## Test plan
- Single request: req 2 op=3'b010, a=5, b=3, `resp_ready`=1. Expect grant in cycle 0, `alu_sel`=010 from cycle 1, `resp_valid` at cycle 3 with id=2, result=driven ALU model value.
- All four valid continuously, `resp_ready`=1: grants go 0,1,2,3,0, spaced 4 cycles apart (SETTLE_CYCLES=2).
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP. `resp_*` stays stable, `req_ready` stays 0, and there is no new grant until accept.
- Reset pulse during SETTLE: all outputs go 0 immediately; after release, the pending request is re-granted from `rr_ptr`=0.
- Flag capture: ALU model returns result 0, flags 3'b001. Expect `resp_flags`=001; inputs change after capture → `resp_flags` unchanged.
- With `ALU_ARB_PRIO0_EN`: reqs 0 and 3 continuously valid → every grant goes to 0. Drop req 0 → 3 is granted next.
